// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit: opcodes, functs,
// ALU codes, mux selects, FSM states and the decoded-instruction record.
package mc_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_XORI  = 6'b001110;

  localparam logic [5:0] FN_NOP     = 6'b000000;
  localparam logic [5:0] FN_ADD     = 6'b100000;
  localparam logic [5:0] FN_SUB     = 6'b100010;
  localparam logic [5:0] FN_SLT     = 6'b101010;
  localparam logic [5:0] FN_JR      = 6'b001000;
  localparam logic [5:0] FN_SYSCALL = 6'b001100;

  localparam logic [5:0] ALU_ADD  = 6'b100000;
  localparam logic [5:0] ALU_SUB  = 6'b100010;
  localparam logic [5:0] ALU_XOR  = 6'b100110;
  localparam logic [5:0] ALU_SLT  = 6'b101010;
  localparam logic [5:0] ALU_NONE = 6'b101100;

  localparam logic [1:0] PC_SRC_ALU  = 2'd0;
  localparam logic [1:0] PC_SRC_OUT  = 2'd1;
  localparam logic [1:0] PC_SRC_JUMP = 2'd2;
  localparam logic [1:0] PC_SRC_RS   = 2'd3;

  localparam logic [1:0] REG_DST_RT = 2'd0;
  localparam logic [1:0] REG_DST_RD = 2'd1;
  localparam logic [1:0] REG_DST_RA = 2'd2;

  localparam logic [1:0] M2R_ALU = 2'd0;
  localparam logic [1:0] M2R_MDR = 2'd1;
  localparam logic [1:0] M2R_PC  = 2'd2;

  localparam logic [1:0] SRCB_B      = 2'd0;
  localparam logic [1:0] SRCB_4      = 2'd1;
  localparam logic [1:0] SRCB_IMM    = 2'd2;
  localparam logic [1:0] SRCB_IMM_SH = 2'd3;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEM_ADDR, S_MEM_RD, S_MEM_WB, S_MEM_WR,
    S_EXEC_R, S_EXEC_I, S_ALU_WB, S_BRANCH, S_JUMP, S_HALT
  } state_t;

  typedef enum logic [2:0] {
    CLS_MEM, CLS_R, CLS_I, CLS_BRANCH, CLS_JUMP, CLS_HALT, CLS_NOP, CLS_ILLEGAL
  } cls_t;

  typedef enum logic [1:0] {JK_J, JK_JAL, JK_JR} jk_t;

  typedef struct packed {
    cls_t       cls;
    logic       is_load;
    jk_t        jk;
    logic [5:0] alu_op;
  } dec_t;

endpackage

// File: rtl/mc_decode.sv
// Combinational opcode/funct classifier feeding the multi-cycle FSM.
module mc_decode
  import mc_ctrl_pkg::*;
(
  input  logic [5:0] i_opcode,
  input  logic [5:0] i_funct,
  output dec_t       o_dec
);

  always_comb begin
    o_dec.cls     = CLS_ILLEGAL;
    o_dec.is_load = 1'b0;
    o_dec.jk      = JK_J;
    o_dec.alu_op  = ALU_ADD;
    case (i_opcode)
      OP_RTYPE: begin
        case (i_funct)
          FN_ADD:     begin o_dec.cls = CLS_R; o_dec.alu_op = ALU_ADD; end
          FN_SUB:     begin o_dec.cls = CLS_R; o_dec.alu_op = ALU_SUB; end
          FN_SLT:     begin o_dec.cls = CLS_R; o_dec.alu_op = ALU_SLT; end
          FN_JR:      begin o_dec.cls = CLS_JUMP; o_dec.jk = JK_JR; end
          FN_SYSCALL: o_dec.cls = CLS_HALT;
          FN_NOP:     o_dec.cls = CLS_NOP;
          default:    o_dec.cls = CLS_ILLEGAL;
        endcase
      end
      OP_LW:   begin o_dec.cls = CLS_MEM; o_dec.is_load = 1'b1; end
      OP_SW:   o_dec.cls = CLS_MEM;
      OP_J:    begin o_dec.cls = CLS_JUMP; o_dec.jk = JK_J; end
      OP_JAL:  begin o_dec.cls = CLS_JUMP; o_dec.jk = JK_JAL; end
      OP_BNE:  begin o_dec.cls = CLS_BRANCH; o_dec.alu_op = ALU_SUB; end
      OP_ADDI: begin o_dec.cls = CLS_I; o_dec.alu_op = ALU_ADD; end
      OP_XORI: begin o_dec.cls = CLS_I; o_dec.alu_op = ALU_XOR; end
      default: o_dec.cls = CLS_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS sequencer. Define MC_MEM_HANDSHAKE_EN to make FETCH,
// MEM_RD and MEM_WR wait on mem_ready; otherwise each takes one cycle.
module multicycle_control
  import mc_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic [1:0] pc_src,
  output logic       ir_write,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       reg_write,
  output logic [1:0] reg_dst,
  output logic [1:0] mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [5:0] alu_op,
  output logic       retire,
  output logic       illegal,
  output logic       halted,
  output state_t     o_dbg_state
);

  state_t r_state, w_next;
  dec_t   r_dec, w_dec;
  logic   w_ready;

  // Memory handshake: a request (mem_read/mem_write) and its address select
  // are held steady until the cycle in which mem_ready is high; that cycle
  // completes the access and the FSM advances on the following edge.
`ifdef MC_MEM_HANDSHAKE_EN
  assign w_ready = mem_ready;
`else
  assign w_ready = 1'b1 | mem_ready;
`endif

  mc_decode u_decode (
    .i_opcode (opcode),
    .i_funct  (funct),
    .o_dec    (w_dec)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= S_FETCH;
      r_dec   <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_DECODE) r_dec <= w_dec;
    end
  end

  assign o_dbg_state = r_state;

  always_comb begin
    w_next     = r_state;
    pc_write   = 1'b0;
    pc_src     = PC_SRC_ALU;
    ir_write   = 1'b0;
    i_or_d     = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = REG_DST_RT;
    mem_to_reg = M2R_ALU;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_B;
    alu_op     = ALU_NONE;
    retire     = 1'b0;
    illegal    = 1'b0;
    halted     = 1'b0;
    case (r_state)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRCB_4;
        alu_op    = ALU_ADD;
        if (w_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          w_next   = S_DECODE;
        end
      end
      S_DECODE: begin
        // ALUOut captures PC+4 + (imm<<2) here so BRANCH can use it.
        alu_src_b = SRCB_IMM_SH;
        alu_op    = ALU_ADD;
        case (w_dec.cls)
          CLS_MEM:    w_next = S_MEM_ADDR;
          CLS_R:      w_next = S_EXEC_R;
          CLS_I:      w_next = S_EXEC_I;
          CLS_BRANCH: w_next = S_BRANCH;
          CLS_JUMP:   w_next = S_JUMP;
          CLS_HALT:   w_next = S_HALT;
          CLS_NOP:    begin retire = 1'b1; w_next = S_FETCH; end
          default:    begin retire = 1'b1; illegal = 1'b1; w_next = S_FETCH; end
        endcase
      end
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        alu_op    = ALU_ADD;
        w_next    = r_dec.is_load ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
        if (w_ready) w_next = S_MEM_WB;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = M2R_MDR;
        retire     = 1'b1;
        w_next     = S_FETCH;
      end
      S_MEM_WR: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
        if (w_ready) begin
          retire = 1'b1;
          w_next = S_FETCH;
        end
      end
      S_EXEC_R: begin
        alu_src_a = 1'b1;
        alu_op    = r_dec.alu_op;
        w_next    = S_ALU_WB;
      end
      S_EXEC_I: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        alu_op    = r_dec.alu_op;
        w_next    = S_ALU_WB;
      end
      S_ALU_WB: begin
        reg_write = 1'b1;
        reg_dst   = (r_dec.cls == CLS_R) ? REG_DST_RD : REG_DST_RT;
        retire    = 1'b1;
        w_next    = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_SUB;
        pc_write  = ~zero;
        pc_src    = PC_SRC_OUT;
        retire    = 1'b1;
        w_next    = S_FETCH;
      end
      S_JUMP: begin
        pc_write = 1'b1;
        retire   = 1'b1;
        w_next   = S_FETCH;
        case (r_dec.jk)
          JK_JR:  pc_src = PC_SRC_RS;
          JK_JAL: begin
            pc_src     = PC_SRC_JUMP;
            reg_write  = 1'b1;
            reg_dst    = REG_DST_RA;
            mem_to_reg = M2R_PC;
          end
          default: pc_src = PC_SRC_JUMP;
        endcase
      end
      S_HALT:  halted = 1'b1;
      default: w_next = S_FETCH;
    endcase
    // Reset masks every output so an abandoned instruction writes nothing.
    if (!reset_n) begin
      pc_write   = 1'b0;
      pc_src     = PC_SRC_ALU;
      ir_write   = 1'b0;
      i_or_d     = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      reg_write  = 1'b0;
      reg_dst    = REG_DST_RT;
      mem_to_reg = M2R_ALU;
      alu_src_a  = 1'b0;
      alu_src_b  = SRCB_B;
      alu_op     = ALU_NONE;
      retire     = 1'b0;
      illegal    = 1'b0;
      halted     = 1'b0;
    end
  end

endmodule
